spi_xfer_queue: RTL and testbench
=================================

SPI_XFER_QUEUE -- requirements
Module: spi_xfer_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entries per FIFO (power of two, 2..16).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle clocks between consecutive transfers (0..255).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tx_data  input  8  byte to transmit.
REQ-006 SHALL have port tx_valid  input  1  tx_data offered.
REQ-007 SHALL have port tx_ready  output  1  TX FIFO not full.
REQ-008 SHALL have port rx_data  output  8  received byte at RX FIFO head.
REQ-009 SHALL have port rx_valid  output  1  RX FIFO not empty.
REQ-010 SHALL have port rx_ready  input  1  consumer pops rx_data.
REQ-011 SHALL have port spi_start  output  1  one-cycle start pulse to SPI master.
REQ-012 SHALL have port spi_data_in  output  8  byte presented to SPI master.
REQ-013 SHALL have port spi_cs  input  1  master chip select, low = transfer in progress.
REQ-014 SHALL have port spi_data_out  input  8  master's latched receive byte.
REQ-015 SHALL have port busy  output  1  FSM not IDLE or TX FIFO non-empty.
REQ-016 SHALL have port rx_overflow  output  1  sticky: received byte dropped, RX FIFO full.

Function
REQ-017 TX push SHALL occur when tx_valid && tx_ready; RX pop when rx_valid && rx_ready; simultaneous push/pop on the same FIFO SHALL keep count unchanged, including when full.
REQ-018 FSM states SHALL be IDLE, START, WAIT_LOW, WAIT_HIGH, CAPTURE, GAP.
REQ-019 IDLE: TX FIFO non-empty SHALL pop head into spi_data_in register and go to START.
REQ-020 START: spi_start SHALL be 1 for exactly this one cycle; next state WAIT_LOW.
REQ-021 WAIT_LOW: spi_cs==0 SHALL go to WAIT_HIGH; spi_start SHALL stay 0 while waiting.
REQ-022 WAIT_HIGH: spi_cs==1 SHALL go to CAPTURE.
REQ-023 CAPTURE: spi_data_out SHALL be pushed into RX FIFO; if full and no pop this cycle, byte SHALL be dropped and rx_overflow set; next state GAP (or IDLE if GAP_CYCLES==0).
REQ-024 GAP: 8-bit counter SHALL count GAP_CYCLES clocks, then IDLE.
REQ-025 spi_data_in SHALL remain stable from START until next IDLE pop.
REQ-026 Start-to-start spacing SHALL be transfer length + GAP_CYCLES + 4 clocks minimum for back-to-back queued bytes.
REQ-027 Bytes SHALL be transmitted and received in strict FIFO order; one RX byte per TX byte.
REQ-028 rx_overflow SHALL clear only on reset.

Reset
REQ-029 On rst: state IDLE, both FIFOs empty, spi_start 0, spi_data_in 0x00, rx_data 0x00, rx_valid 0, tx_ready 1, busy 0, rx_overflow 0, gap counter 0.
REQ-030 Reset mid-transfer SHALL discard all queued and in-flight bytes with no further spi_start.

Configuration
REQ-031 Macro SPI_XFER_QUEUE_RX_EN defined: RX FIFO and rx_overflow as above.
REQ-032 Macro undefined: no RX FIFO; CAPTURE discards byte; rx_valid, rx_data, rx_overflow tied 0; TX path unchanged.

Structure
REQ-033 Shared package spi_pkg SHALL hold FSM state encodings and GAP counter width.
REQ-034 One sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) SHALL be instanced for TX and RX.

Verification (bench pairs block with SPI master, MISO loopback)
REQ-035 Push 0xA5 -> one spi_start pulse, MOSI 10100101, rx_data 0xA5, rx_valid 1 after cs rises.
REQ-036 Push 0x01,0x02,0x03,0x04 back-to-back -> tx_ready 0 after 4th, four transfers in order, RX yields 0x01..0x04.
REQ-037 Hold rx_ready 0, send 5 bytes with DEPTH 4 -> RX holds first 4, rx_overflow 1 after 5th CAPTURE.
REQ-038 GAP_CYCLES 10, two queued bytes -> exactly 10 clocks in GAP between CAPTURE and next IDLE pop.
REQ-039 Assert rst during WAIT_HIGH with 2 bytes queued -> all outputs to reset values, no spi_start after release.
REQ-040 Build without SPI_XFER_QUEUE_RX_EN, send 0x5A -> transfer completes, rx_valid stays 0.

Source files
------------

// File: rtl/spi_xfer_queue_pkg.sv
// Shared types for the SPI transfer queue: FSM state encoding and gap counter width.
package spi_pkg;

  localparam int BYTE_W    = 8;
  localparam int GAP_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_GAP       = 3'd5
  } state_e;

endpackage

// File: rtl/spi_xfer_queue_sync_fifo.sv
// Synchronous FIFO used for both the TX and RX byte queues.
// A push while full is accepted only if a pop happens in the same cycle,
// so push+pop always leaves the count unchanged. Read data reads 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/spi_xfer_queue.sv
// SPI transfer queue: buffers bytes for an external SPI master, sequences one
// transfer at a time with a programmable idle gap, and queues received bytes.
// Optional feature macro SPI_XFER_QUEUE_RX_EN: when defined, received bytes go
// into an RX FIFO with a sticky overflow flag; when undefined, received bytes
// are discarded and rx_valid/rx_data/rx_overflow are held at 0.
//
// state      | meaning
// IDLE       | waiting for a queued TX byte; pops it into spi_data_in
// START      | spi_start pulse for one cycle
// WAIT_LOW   | waiting for the master to drop chip select
// WAIT_HIGH  | transfer in progress, waiting for chip select to rise
// CAPTURE    | master's received byte is taken
// GAP        | idle spacing of GAP_CYCLES clocks before the next transfer
module spi_xfer_queue
  import spi_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              spi_start,
  output logic [BYTE_W-1:0] spi_data_in,
  input  logic              spi_cs,
  input  logic [BYTE_W-1:0] spi_data_out,
  output logic              busy,
  output logic              rx_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e               state_q, state_d;
  logic [BYTE_W-1:0]    data_q, data_d;
  logic                 start_q, start_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [BYTE_W-1:0]    tx_head;
  logic [CW-1:0]        tx_count;
  logic                 tx_unused;

  assign tx_ready  = !tx_full;
  assign tx_push   = tx_valid && tx_ready;
  assign tx_unused = ^tx_count;

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_push),
    .wr_data (tx_data),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

`ifdef SPI_XFER_QUEUE_RX_EN
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0]        rx_count;
  logic                 ovf_q, ovf_d;
  logic                 rx_unused;

  assign rx_valid    = !rx_empty;
  assign rx_pop      = rx_valid && rx_ready;
  assign rx_overflow = ovf_q;
  assign rx_unused   = ^rx_count;

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rx_push),
    .wr_data (spi_data_out),
    .pop     (rx_pop),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  // A byte is dropped only when the RX FIFO is full and nothing leaves it this cycle.
  always_comb begin
    rx_push = (state_q == ST_CAPTURE);
    ovf_d   = ovf_q;
    if (rx_push && rx_full && !rx_pop) ovf_d = 1'b1;
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
`else
  logic rx_unused;

  assign rx_valid    = 1'b0;
  assign rx_data     = '0;
  assign rx_overflow = 1'b0;
  assign rx_unused   = rx_ready ^ (^spi_data_out);
`endif

  assign spi_start   = start_q;
  assign spi_data_in = data_q;
  assign busy        = (state_q != ST_IDLE) || !tx_empty;

  // Transfer sequencing: next state, TX pop, start pulse and gap counting.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    start_d = 1'b0;
    gap_d   = gap_q;
    tx_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          data_d  = tx_head;
          start_d = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!spi_cs) state_d = ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: begin
        if (spi_cs) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (GAP_CYCLES == 0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d   = GAP_CNT_W'(GAP_CYCLES);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_d = gap_q - GAP_CNT_W'(1);
        if (gap_q <= GAP_CNT_W'(1)) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; start_q is high exactly while in START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      start_q <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      start_q <= start_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Bench for spi_xfer_queue with a behavioural SPI master in MISO loopback.
module tb_spi_xfer_queue;

  localparam int DEPTH   = 4;
  localparam int GAP     = 10;
  localparam int SPACING = 8 + GAP + 4;

`ifdef SPI_XFER_QUEUE_RX_EN
  localparam bit RX = 1'b1;
`else
  localparam bit RX = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       spi_start;
  logic [7:0] spi_data_in;
  logic       spi_cs;
  logic [7:0] spi_data_out;
  logic       busy;
  logic       rx_overflow;

  spi_xfer_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_cs       (spi_cs),
    .spi_data_out (spi_data_out),
    .busy         (busy),
    .rx_overflow  (rx_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int         cyc = 0;
  int         start_hi = 0;
  int         stab_err = 0;
  logic [7:0] xfers[$];
  int         start_t[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (spi_start === 1'b1) start_hi <= start_hi + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SPI master model: cs low for 8 clocks, serialises spi_data_in MSB first,
  // loops the shifted bits back as the received byte.
  initial begin : master
    logic [7:0] b, sh;
    bit aborted;
    spi_cs = 1'b1;
    spi_data_out = 8'h00;
    sh = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && spi_start === 1'b1) begin
        b = spi_data_in;
        start_t.push_back(cyc);
        aborted = 1'b0;
        @(negedge clk);
        spi_cs = 1'b0;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          sh = {sh[6:0], spi_data_in[7-i]};
          if (spi_data_in !== b) stab_err++;
        end
        if (!aborted) begin
          spi_data_out = sh;
          xfers.push_back(sh);
        end
        spi_cs = 1'b1;
      end
    end
  end

  task automatic wait_xfers(input int n, input string nm);
    int t = 0;
    while (xfers.size() < n && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check({nm, "_xfer_timeout"}, 32'(xfers.size() >= n), 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (busy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic push(input logic [7:0] d);
    int t = 0;
    while (!tx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop_check(input string nm, input logic [7:0] exp);
    check({nm, "_rx_valid"}, 32'(rx_valid), 32'(RX));
    check({nm, "_rx_data"}, 32'(rx_data), RX ? 32'(exp) : 32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mosi;
  } vec_t;

  vec_t tbl[5];

  initial begin : stim
    int base, sbase;
    tbl[0] = '{tx: 8'hA5, mosi: 8'b10100101};
    tbl[1] = '{tx: 8'h00, mosi: 8'b00000000};
    tbl[2] = '{tx: 8'hFF, mosi: 8'b11111111};
    tbl[3] = '{tx: 8'h3C, mosi: 8'b00111100};
    tbl[4] = '{tx: 8'h81, mosi: 8'b10000001};

    rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("init_rx_valid", 32'(rx_valid), 32'd0);
    check("init_rx_data", 32'(rx_data), 32'd0);
    check("init_spi_start", 32'(spi_start), 32'd0);
    check("init_spi_data_in", 32'(spi_data_in), 32'd0);
    check("init_overflow", 32'(rx_overflow), 32'd0);

    // Single-byte transfers from the vector table.
    for (int v = 0; v < 5; v++) begin
      wait_idle("tbl");
      base  = xfers.size();
      sbase = start_t.size();
      push(tbl[v].tx);
      wait_xfers(base + 1, "tbl");
      check("tbl_start_count", 32'(start_t.size() - sbase), 32'd1);
      check("tbl_mosi", 32'(xfers[base]), 32'(tbl[v].mosi));
      pop_check("tbl", tbl[v].mosi);
    end

    // Burst of four pushed while the FSM sits in GAP: TX FIFO fills.
    base  = xfers.size();
    sbase = start_t.size();
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    check("burst_tx_ready_full", 32'(tx_ready), 32'd0);
    check("burst_busy", 32'(busy), 32'd1);
    wait_xfers(base + 4, "burst");
    for (int i = 0; i < 4; i++)
      check("burst_order", 32'(xfers[base+i]), 32'(i + 1));
    for (int i = 0; i < 3; i++)
      check("burst_spacing", 32'(start_t[sbase+i+1] - start_t[sbase+i]), 32'(SPACING));
    for (int i = 0; i < 4; i++)
      pop_check("burst", 8'(i + 1));
    check("burst_rx_empty", 32'(rx_valid), 32'd0);
    check("burst_no_overflow", 32'(rx_overflow), 32'd0);

    // Overflow: five bytes with the consumer stalled.
    wait_idle("ovf");
    base = xfers.size();
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    wait_xfers(base + 4, "ovf4");
    check("ovf_before_5th", 32'(rx_overflow), 32'd0);
    wait_xfers(base + 5, "ovf5");
    check("ovf_after_5th", 32'(rx_overflow), 32'(RX));
    for (int i = 0; i < 4; i++)
      pop_check("ovf", 8'h10 + 8'(i));
    check("ovf_rx_empty", 32'(rx_valid), 32'd0);
    check("ovf_sticky", 32'(rx_overflow), 32'(RX));

    // Reset in WAIT_HIGH with two bytes still queued.
    wait_idle("rst");
    base  = xfers.size();
    sbase = start_t.size();
    push(8'h20); push(8'h21); push(8'h22);
    begin
      int t = 0;
      while (spi_cs && t < 200) begin
        @(negedge clk);
        t++;
      end
      check("rst_cs_low_timeout", 32'(spi_cs), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx_ready", 32'(tx_ready), 32'd1);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    check("midrst_spi_start", 32'(spi_start), 32'd0);
    check("midrst_spi_data_in", 32'(spi_data_in), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_overflow", 32'(rx_overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("postrst_starts", 32'(start_t.size() - sbase), 32'd1);
    check("postrst_xfers", 32'(xfers.size() - base), 32'd0);
    check("postrst_busy", 32'(busy), 32'd0);

    check("start_pulse_width", 32'(start_hi), 32'(start_t.size()));
    check("spi_data_in_stable", 32'(stab_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
